// File: rtl/regfile_mp.sv
// regfile_mp: NRD registered read ports, one synchronous write port, hardwired-zero entry 0,
// and a clear sweep after reset or clr. Define REGFILE_BYPASS_EN for write-first collisions.
module regfile_mp #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  output logic                 busy,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*WIDTH-1:0] rd,
  input  logic                 we,
  input  logic [AW-1:0]        wa,
  input  logic [WIDTH-1:0]     wd
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  state_e               state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic [NRD*WIDTH-1:0] rd_q, rd_d;

  // Entry 0 has no storage; it always reads as zero.
  logic [WIDTH-1:0]     mem_q [1:DEPTH-1];

  logic                 write_ok;
  logic                 sweep_wr;

  assign write_ok = !reset && (state_q == StRun) && we && (wa != '0) && (32'(wa) < DEPTH);
  assign sweep_wr = !reset && (state_q == StClear);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        if (cnt_q == LastIdx) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      StRun: begin
        if (clr) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StClear;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == StClear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StClear;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
    end
  end

  // The sweep owns the array while clearing; normal writes only land in RUN.
  always_ff @(posedge clk) begin
    for (int unsigned e = 1; e < DEPTH; e++) begin
      if (sweep_wr && (cnt_q == AW'(e))) begin
        mem_q[e] <= '0;
      end else if (write_ok && (wa == AW'(e))) begin
        mem_q[e] <= wd;
      end
    end
  end

  always_comb begin
    rd_d = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      for (int unsigned e = 1; e < DEPTH; e++) begin
        if (ra[i*AW +: AW] == AW'(e)) begin
          rd_d[i*WIDTH +: WIDTH] = mem_q[e];
        end
      end
`ifdef REGFILE_BYPASS_EN
      if (write_ok && (wa == ra[i*AW +: AW])) begin
        rd_d[i*WIDTH +: WIDTH] = wd;
      end
`endif
      if (busy_q) begin
        rd_d[i*WIDTH +: WIDTH] = '0;
      end
    end
  end

  assign busy = busy_q;
  assign rd   = rd_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a 32-entry and a 20-entry instance, reads checked
// against a bench-side model through an expected-value queue.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clr, we, busy;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [4:0]  wa;
  logic [31:0] wd;

  logic        reset20, clr20, we20, busy20;
  logic [9:0]  ra20;
  logic [63:0] rd20;
  logic [4:0]  wa20;
  logic [31:0] wd20;

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NRD(2)) dut (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy), .ra(ra), .rd(rd),
    .we(we), .wa(wa), .wd(wd)
  );

  regfile_mp #(.WIDTH(32), .DEPTH(20), .NRD(2)) dut20 (
    .clk(clk), .reset(reset20), .clr(clr20), .busy(busy20), .ra(ra20), .rd(rd20),
    .we(we20), .wa(wa20), .wd(wd20)
  );

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] exp;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] m32 [32];
  logic [31:0] m20 [20];
  int          checks = 0;
  int          failures = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input bit s, input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (s) return (a < 5'd20) ? m20[a] : 32'h0;
    return m32[a];
  endfunction

  task automatic drain();
    sb_t         x;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      case (x.port)
        0:       obs = rd[31:0];
        1:       obs = rd[63:32];
        2:       obs = rd20[31:0];
        default: obs = rd20[63:32];
      endcase
      check(x.tag, obs, x.exp);
    end
  endtask

  // One RUN-mode cycle on the selected instance (s=1: 20-entry), reads checked next edge.
  task automatic cyc(input bit s, input bit w, input logic [4:0] a, input logic [31:0] d,
                     input logic [4:0] r0, input logic [4:0] r1, input string tag);
    logic [4:0]  rr [2];
    logic [4:0]  dep;
    sb_t         x;
    dep   = s ? 5'd20 : 5'd31;
    rr[0] = r0;
    rr[1] = r1;
    if (s) begin
      we20 = w; wa20 = a; wd20 = d; ra20 = {r1, r0};
    end else begin
      we = w; wa = a; wd = d; ra = {r1, r0};
    end
    for (int i = 0; i < 2; i++) begin
      x.tag  = $sformatf("%s_p%0d_a%0d", tag, i, rr[i]);
      x.port = (s ? 2 : 0) + i;
      x.exp  = model_rd(s, rr[i]);
      if (Bypass && w && (rr[i] == a) && (a != 5'd0) && (s ? (a < dep) : 1'b1)) x.exp = d;
      sbq.push_back(x);
    end
    step();
    if (w && (a != 5'd0)) begin
      if (s) begin
        if (a < dep) m20[a] = d;
      end else begin
        m32[a] = d;
      end
    end
    if (s) we20 = 1'b0; else we = 1'b0;
    drain();
  endtask

  int f32, f20, hi;

  initial begin
    reset = 1'b1; clr = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0;
    reset20 = 1'b1; clr20 = 1'b0; we20 = 1'b0; wa20 = '0; wd20 = '0; ra20 = '0;
    step();
    step();
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_rd", rd[31:0] | rd[63:32], 32'd0);
    check("rst_busy20", {31'd0, busy20}, 32'd1);
    check("rst_rd20", rd20[31:0] | rd20[63:32], 32'd0);

    // Initial sweep: busy falls on edge DEPTH after release, rd stays 0 meanwhile.
    ra = {5'd3, 5'd1};
    ra20 = {5'd3, 5'd1};
    reset = 1'b0;
    reset20 = 1'b0;
    f32 = 0;
    f20 = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (f32 == 0 && !busy) f32 = k;
      if (f20 == 0 && !busy20) f20 = k;
      check("sweep_rd", rd[31:0] | rd[63:32], 32'd0);
      if (f32 != 0 && f20 != 0) break;
    end
    check("sweep_len32", 32'(f32), 32'd32);
    check("sweep_len20", 32'(f20), 32'd20);
    for (int i = 0; i < 32; i++) m32[i] = 32'h0;
    for (int i = 0; i < 20; i++) m20[i] = 32'h0;

    // Basic write then dual-port read of the same entry.
    cyc(0, 1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, "wr5");
    cyc(0, 0, 5'd0, 32'h0, 5'd5, 5'd5, "rd5");
    cyc(0, 1, 5'd31, 32'hCAFE0031, 5'd5, 5'd31, "wr31");
    cyc(0, 0, 5'd0, 32'h0, 5'd31, 5'd5, "rd31");
    cyc(0, 1, 5'd0, 32'h00000077, 5'd0, 5'd0, "w0_big");
    cyc(0, 0, 5'd0, 32'h0, 5'd0, 5'd31, "rd0_big");

    // Entry 0 and out-of-range writes on the 20-entry instance.
    for (int i = 1; i < 20; i++) cyc(1, 1, 5'(i), 32'(i * 3 + 100), 5'd0, 5'd0, "fill20");
    cyc(1, 1, 5'd0, 32'h1234, 5'd0, 5'd0, "w0_20");
    cyc(1, 1, 5'd25, 32'h55, 5'd0, 5'd25, "w25_20");
    cyc(1, 0, 5'd0, 32'h0, 5'd0, 5'd25, "rd0_25");
    for (int i = 1; i < 20; i += 2) cyc(1, 0, 5'd0, 32'h0, 5'(i), 5'(i + 1), "keep20");

    // Same-address read and write.
    cyc(0, 1, 5'd7, 32'hA, 5'd0, 5'd0, "coll_init");
    cyc(0, 1, 5'd7, 32'hB, 5'd7, 5'd6, "coll");
    cyc(0, 0, 5'd0, 32'h0, 5'd7, 5'd7, "coll_after");

    // Clear request with writes and a second clr during the sweep.
    for (int i = 1; i < 32; i++) cyc(0, 1, 5'(i), 32'(i), 5'd0, 5'd0, "fill32");
    cyc(0, 0, 5'd0, 32'h0, 5'd31, 5'd3, "fill_chk");
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_busy_rise", {31'd0, busy}, 32'd1);
    hi = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      hi++;
      we = 1'b1; wa = 5'd3; wd = 32'hFFFF; ra = {5'd3, 5'd31};
      clr = (k == 5);
      step();
      check("clr_rd", rd[31:0] | rd[63:32], 32'd0);
    end
    we = 1'b0;
    clr = 1'b0;
    check("clr_busy_len", 32'(hi), 32'd32);
    for (int i = 0; i < 32; i++) m32[i] = 32'h0;
    for (int i = 0; i < 32; i += 2) cyc(0, 0, 5'd0, 32'h0, 5'(i), 5'(i + 1), "clr_zero");

    // Reset ten cycles into a sweep restarts it from entry 0.
    cyc(0, 1, 5'd20, 32'h2020, 5'd0, 5'd0, "pre_rst20");
    cyc(0, 1, 5'd25, 32'h2525, 5'd20, 5'd0, "pre_rst25");
    clr = 1'b1;
    step();
    clr = 1'b0;
    ra = {5'd25, 5'd20};
    repeat (10) step();
    reset = 1'b1;
    step();
    check("mid_rst_busy", {31'd0, busy}, 32'd1);
    check("mid_rst_rd", rd[31:0] | rd[63:32], 32'd0);
    reset = 1'b0;
    f32 = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (!busy) begin
        f32 = k;
        break;
      end
    end
    check("mid_rst_len", 32'(f32), 32'd32);
    for (int i = 0; i < 32; i++) m32[i] = 32'h0;
    cyc(0, 0, 5'd0, 32'h0, 5'd20, 5'd25, "post_rst_zero");
    cyc(0, 1, 5'd9, 32'h99, 5'd0, 5'd0, "post_rst_w");
    cyc(0, 0, 5'd0, 32'h0, 5'd9, 5'd0, "post_rst_r");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file, the next-generation replacement for the 32-entry, two-read-port regfile in the datapath. It has a synchronous write port, registered read ports, and a hardwired-zero entry 0. A clear sequencer sweeps every entry to zero after reset or on request, and signals `busy` while the sweep runs. It sits between decode (read addresses) and writeback (write port).

## Interface
- `WIDTH`, 32, data width of each entry.
- `DEPTH`, 32, number of entries (≥2, need not be a power of two).
- `NRD`, 2, number of read ports (1..4).
- `AW`, `$clog2(DEPTH)`, address width (derived; do not override).
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `clr`  in  1  single-cycle request to start a clear sweep.
- `busy`  out  1  high while a clear sweep is in progress.
- `ra`  in  NRD*AW  read addresses; port i is `ra[i*AW +: AW]`.
- `rd`  out  NRD*WIDTH  registered read data; port i is `rd[i*WIDTH +: WIDTH]`.
- `we`  in  1  write enable.
- `wa`  in  AW  write address.
- `wd`  in  WIDTH  write data.

## Operation
- FSM states:
  - CLEAR: the sweep counter `cnt` (AW bits) writes zero to entry `cnt` each cycle.
  - RUN: normal operation.
- Transitions:
  - `reset` → CLEAR with `cnt`=0.
  - CLEAR with `cnt`==DEPTH-1 → RUN, after clearing that last entry.
  - RUN with `clr`=1 → CLEAR with `cnt`=0.
  - `clr` is ignored while in CLEAR; the sweep does not restart.
- `busy` = (state==CLEAR), registered.
- Writes in RUN: when `we`=1, `wa`≠0 and `wa`<DEPTH, entry `wa` ← `wd` at the edge.
  - Writes to 0 or to an out-of-range address are dropped.
- Writes in CLEAR: `we` is ignored, and the write is lost (not queued).
- Reads: at each edge, `rd[i]` ← entry `ra[i]`.
  - Entry 0 and out-of-range addresses return 0.
  - While `busy`=1, every `rd[i]` loads 0.
- Same-address read and write in one cycle: behaviour is set by `REGFILE_BYPASS_EN` (see Configuration).
- Several read ports may name the same address; each returns the same value.

## Timing
- Reset values: `rd`=0 on all ports, `busy`=1, state CLEAR, `cnt`=0. Entry contents are undefined until the sweep completes.
- Holding `reset` high keeps `cnt`=0.
- After `reset` falls, the sweep takes DEPTH rising edges. `busy` falls on edge DEPTH, and the first accepted write is on edge DEPTH+1.
- Reset asserted mid-sweep or mid-RUN: the next edge restarts the sweep at `cnt`=0 and drives `rd` to 0.
- `clr` sampled high in RUN: `busy` rises at the next edge. Any write presented in that same cycle is still performed; the sweep then overwrites it.
- Read latency is 1 cycle: `ra` presented in cycle n gives `rd` valid after edge n+1.
- Write latency is 1 cycle: a write at edge n is visible to a read addressed in cycle n+1.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: write-first. If `we`=1 and `wa`==`ra[i]` (nonzero, in range, RUN) in the same cycle, `rd[i]` loads `wd`.
- Undefined: read-before-write. `rd[i]` loads the old entry contents in that case.
- Everything else is identical in both builds.

## Test plan
- Reset then sweep (DEPTH=32): deassert `reset`. `busy`=1 for exactly 32 cycles and falls on the 32nd edge. `rd`=0 throughout.
- Write/read: write 0xDEADBEEF to entry 5. Next cycle `ra0`=5, `ra1`=5. After one edge both ports read 0xDEADBEEF.
- Entry 0 and range (DEPTH=20):
  - Write 0x1234 to entry 0 and 0x55 to entry 25.
  - Reading entry 0 → 0 and entry 25 → 0.
  - Entries 1..19 are unchanged.
- Collision:
  - Entry 7 holds 0xA. Write 0xB to entry 7 while `ra0`=7.
  - With `REGFILE_BYPASS_EN` defined, `rd0`=0xB; without it, `rd0`=0xA.
  - Entry 7 reads 0xB the following cycle in both builds.
- Clear request:
  - Fill entries 1..31 with their index, then pulse `clr`.
  - `busy`=1 for 32 cycles, and writes issued during the sweep are dropped.
  - Afterwards every entry reads 0.
  - A second `clr` pulsed mid-sweep does not extend `busy`.
- Reset mid-sweep: assert `reset` at sweep cycle 10. `cnt` returns to 0, and `busy` stays high for 32 cycles after release.
